// File: rtl/pipe_stage_buf.sv
// pipe_stage_buf: valid/ready pipeline-stage register with a one-entry skid
// buffer, flush-to-bubble and acknowledge-driven clearing of selected bits.
// in_ready depends only on registered state (and reset), never on out_ready.
module pipe_stage_buf #(
  parameter int unsigned          DATA_W        = 32,
  parameter logic [DATA_W-1:0]    CLR_MASK      = '0,
  parameter bit                   ZERO_ON_FLUSH = 1'b1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              flush,
  input  logic              ack,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
);

  // Encoding keeps bit0 = main valid, bit1 = skid valid.
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b01,
    FULL  = 2'b11
  } state_t;

  state_t            state;
  logic [DATA_W-1:0] main_q;
  logic [DATA_W-1:0] skid_q;

  logic main_v;
  logic skid_v;
  logic in_fire;
  logic out_fire;
  logic ack_clr;

  assign main_v    = (state != EMPTY);
  assign skid_v    = (state == FULL);
  assign in_ready  = !skid_v && !RST;
  assign out_valid = main_v;
  assign out_data  = main_q;
  assign occupancy = {1'b0, main_v} + {1'b0, skid_v};
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = main_v && out_ready;
  assign ack_clr   = ack && main_v && !out_fire;

  // State and storage update: reset, then flush, then handshake/ack.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state  <= EMPTY;
      main_q <= '0;
      skid_q <= '0;
    end else if (flush) begin
      state <= EMPTY;
      if (ZERO_ON_FLUSH) begin
        main_q <= '0;
        skid_q <= '0;
      end
    end else begin
      // Ack clear first; any load of main_q below takes precedence, which only
      // happens together with out_fire, where the clear must be ignored anyway.
      if (ack_clr) main_q <= main_q & ~CLR_MASK;
      case (state)
        EMPTY: begin
          if (in_fire) begin
            main_q <= in_data;
            state  <= ONE;
          end
        end
        ONE: begin
          if (in_fire && out_fire) begin
            main_q <= in_data;
          end else if (in_fire) begin
            skid_q <= in_data;
            state  <= FULL;
          end else if (out_fire) begin
            state <= EMPTY;
          end
        end
        FULL: begin
          if (out_fire) begin
            main_q <= skid_q;
            state  <= ONE;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

endmodule
